// File: rtl/priority_pkg.sv
// Shared types and helpers for the priority grant path.
package priority_pkg;

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [2:0] NONE_CODE = 3'd7;
  localparam int unsigned NUM_REQ = 4;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [2:0] code);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    if (code < 3'(NUM_REQ)) oh[code[1:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/priority_idx_fifo.sv
// Two-entry index FIFO with wrapping pointers; no write-to-read bypass.
module priority_idx_fifo
  import priority_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic       push,
  input  logic [2:0] push_data,
  input  logic       pop,
  output logic [2:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [2:0] r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign full     = (r_count == 2'd2);
  assign empty    = (r_count == 2'd0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_mem[0] <= NONE_CODE;
      r_mem[1] <= NONE_CODE;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/priority_grant_driver.sv
// Turns buffered priority indices into held one-hot grants.
// Optional forced release after HOLD_MAX cycles: define PRIORITY_GRANT_TIMEOUT_EN.
module priority_grant_driver
  import priority_pkg::*;
`ifdef PRIORITY_GRANT_TIMEOUT_EN
#(
  parameter int unsigned HOLD_MAX = 15
)
`endif
(
  input  logic               clk,
  input  logic               rstN,
  input  logic               idx_valid,
  input  logic [2:0]         idx,
  output logic               idx_ready,
  output logic [NUM_REQ-1:0] grant,
  input  logic               grant_done,
  output logic               busy,
  output logic               none_seen,
`ifdef PRIORITY_GRANT_TIMEOUT_EN
  output logic               idx_err,
  output logic               timeout
`else
  output logic               idx_err
`endif
);

  state_e             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_none;
  logic               r_err;
  logic [2:0]         w_head;
  logic [1:0]         w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

`ifdef PRIORITY_GRANT_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout;
  assign timeout = r_timeout;
`endif

  assign idx_ready = (w_count < 2'd2);
  assign w_push    = idx_valid && !w_full;
  // Only an idle FSM pops, so a held grant keeps the queue frozen.
  assign w_pop     = (r_state == StIdle) && !w_empty;
  assign grant     = r_grant;
  assign busy      = (r_state == StGrant);
  assign none_seen = r_none;
  assign idx_err   = r_err;

  priority_idx_fifo u_fifo (
    .clk       (clk),
    .rstN      (rstN),
    .push      (w_push),
    .push_data (idx),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_none     <= 1'b0;
      r_err      <= 1'b0;
`ifdef PRIORITY_GRANT_TIMEOUT_EN
      r_hold_cnt <= 8'd0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_none <= 1'b0;
      r_err  <= 1'b0;
`ifdef PRIORITY_GRANT_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            if (w_head == NONE_CODE) begin
              r_none <= 1'b1;
            end else if (w_head < 3'(NUM_REQ)) begin
              r_grant <= idx_to_onehot(w_head);
              r_state <= StGrant;
`ifdef PRIORITY_GRANT_TIMEOUT_EN
              r_hold_cnt <= 8'd0;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StGrant: begin
          if (grant_done) begin
            r_grant <= '0;
            r_state <= StIdle;
`ifdef PRIORITY_GRANT_TIMEOUT_EN
          end else if (r_hold_cnt == 8'(HOLD_MAX - 1)) begin
            // grant_done has priority over the limit on the same edge
            r_grant   <= '0;
            r_timeout <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_grant_driver.sv
// Randomised and directed checks of priority_grant_driver against a queue-based model.
module tb_priority_grant_driver;
  import priority_pkg::*;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       idx_valid;
  logic [2:0] idx;
  logic       idx_ready;
  logic [3:0] grant;
  logic       grant_done;
  logic       busy;
  logic       none_seen;
  logic       idx_err;
`ifdef PRIORITY_GRANT_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

`ifdef PRIORITY_GRANT_TIMEOUT_EN
  priority_grant_driver #(.HOLD_MAX(HOLD)) dut (
`else
  priority_grant_driver dut (
`endif
    .clk        (clk),
    .rstN       (rstN),
    .idx_valid  (idx_valid),
    .idx        (idx),
    .idx_ready  (idx_ready),
    .grant      (grant),
    .grant_done (grant_done),
    .busy       (busy),
    .none_seen  (none_seen),
`ifdef PRIORITY_GRANT_TIMEOUT_EN
    .idx_err    (idx_err),
    .timeout    (timeout)
`else
    .idx_err    (idx_err)
`endif
  );

  // Reference model: a queue of pending codes plus the grant currently held.
  int         q[$];
  bit         m_busy;
  logic [3:0] m_grant;
  bit         m_none, m_err, m_to;
  int         m_held;

  int vectors = 0;
  int miscompares = 0;

  bit         rec_en = 0;
  logic [3:0] rec[$];
  logic [3:0] prev_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_grant = '0; m_none = 0; m_err = 0; m_to = 0; m_held = 0;
  endtask

  task automatic model_edge();
    bit push;
    int code;
    push = idx_valid && (q.size() < 2);
    m_none = 0; m_err = 0; m_to = 0;
    if (m_busy) begin
      m_held++;
      if (grant_done) begin
        m_busy = 0; m_grant = '0;
      end
`ifdef PRIORITY_GRANT_TIMEOUT_EN
      else if (m_held == HOLD) begin
        m_busy = 0; m_grant = '0; m_to = 1;
      end
`endif
    end else if (q.size() > 0) begin
      code = q.pop_front();
      if (code < 4) begin
        m_grant = 4'(1 << code); m_busy = 1; m_held = 0;
      end else if (code == 7) m_none = 1;
      else m_err = 1;
    end
    if (push) q.push_back(int'(idx));
  endtask

  task automatic compare();
    chk("grant", 32'(grant), 32'(m_grant));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("none_seen", 32'(none_seen), 32'(m_none));
    chk("idx_err", 32'(idx_err), 32'(m_err));
    chk("idx_ready", 32'(idx_ready), 32'(q.size() < 2));
`ifdef PRIORITY_GRANT_TIMEOUT_EN
    chk("timeout", 32'(timeout), 32'(m_to));
`endif
    if (rec_en && grant != 4'b0 && prev_grant == 4'b0) rec.push_back(grant);
    prev_grant = grant;
  endtask

  task automatic cycle(input bit v, input logic [2:0] i, input bit d);
    idx_valid = v; idx = i; grant_done = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    vectors++;
    compare();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || m_busy) && n < 40) begin
      cycle(0, 3'd0, 1);
      n++;
    end
    chk("drain_bound", 32'(q.size() > 0 || m_busy), 32'd0);
  endtask

  initial begin
    bit pushed0;
    rstN = 1'b0; idx_valid = 0; idx = '0; grant_done = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare();
    chk("reset_ready", 32'(idx_ready), 32'd1);
    chk("reset_grant", 32'(grant), 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // Single grant, held until done.
    cycle(1, 3'd2, 0);
    chk("t1_not_yet", 32'(grant), 32'd0);
    cycle(0, 3'd0, 0);
    chk("t1_grant", 32'(grant), 32'b0100);
    cycle(0, 3'd0, 0);
    cycle(0, 3'd0, 0);
    cycle(0, 3'd0, 1);
    chk("t1_release", 32'(grant), 32'd0);

    // Buffer 1, 3, 0 behind a held grant of 2.
    rec_en = 1; rec.delete();
    cycle(1, 3'd2, 0);
    cycle(1, 3'd1, 0);
    cycle(1, 3'd3, 0);
    chk("t2_full_ready", 32'(idx_ready), 32'd0);
    pushed0 = 0;
    for (int n = 0; n < 30; n++) begin
      bit v;
      v = !pushed0;
      if (v && idx_ready) pushed0 = 1;
      cycle(v, 3'd0, grant != 4'b0);
    end
    rec_en = 0;
    chk("t2_count", 32'(rec.size()), 32'd4);
    if (rec.size() == 4) begin
      chk("t2_g0", 32'(rec[0]), 32'b0100);
      chk("t2_g1", 32'(rec[1]), 32'b0010);
      chk("t2_g2", 32'(rec[2]), 32'b1000);
      chk("t2_g3", 32'(rec[3]), 32'b0001);
    end
    drain();

    // None code then illegal code.
    cycle(1, 3'd7, 0);
    cycle(1, 3'd5, 0);
    chk("t3_none", 32'(none_seen), 32'd1);
    cycle(0, 3'd0, 0);
    chk("t3_err", 32'(idx_err), 32'd1);
    chk("t3_none_off", 32'(none_seen), 32'd0);
    chk("t3_grant", 32'(grant), 32'd0);
    cycle(0, 3'd0, 0);
    chk("t3_err_off", 32'(idx_err), 32'd0);

`ifdef PRIORITY_GRANT_TIMEOUT_EN
    cycle(1, 3'd0, 0);
    cycle(1, 3'd1, 0);
    chk("t4_grant", 32'(grant), 32'b0001);
    for (int n = 0; n < HOLD - 1; n++) cycle(0, 3'd0, 0);
    chk("t4_still", 32'(grant), 32'b0001);
    cycle(0, 3'd0, 0);
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_released", 32'(grant), 32'd0);
    cycle(0, 3'd0, 0);
    chk("t4_next", 32'(grant), 32'b0010);
    for (int n = 0; n < HOLD - 1; n++) cycle(0, 3'd0, 0);
    cycle(0, 3'd0, 1);
    chk("t4_done_wins", 32'(timeout), 32'd0);
    chk("t4_done_rel", 32'(grant), 32'd0);
    drain();
`endif

    // Reset while granting with a full queue.
    cycle(1, 3'd3, 0);
    cycle(1, 3'd1, 0);
    cycle(1, 3'd2, 0);
    chk("t5_full", 32'(idx_ready), 32'd0);
    #2 rstN = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant), 32'd0);
    chk("t5_async_ready", 32'(idx_ready), 32'd1);
    model_reset();
    @(negedge clk);
    compare();
    rstN = 1'b1;
    cycle(1, 3'd2, 0);
    cycle(0, 3'd0, 0);
    chk("t5_after", 32'(grant), 32'b0100);
    drain();

    // Simultaneous push and pop at count 1 keeps order.
    cycle(1, 3'd7, 0);
    cycle(1, 3'd2, 0);
    chk("t6_ready", 32'(idx_ready), 32'd1);
    cycle(1, 3'd1, 0);
    chk("t6_first", 32'(grant), 32'b0100);
    cycle(0, 3'd0, 1);
    cycle(0, 3'd0, 0);
    chk("t6_second", 32'(grant), 32'b0010);
    drain();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/priority_grant_driver.md
# priority_grant_driver

Converts encoded priority indices (3-bit, value 7 = "no request") back into one-hot grant lines for four requesters. Buffers up to two indices and holds each grant until the requester signals completion. Sits downstream of the priority decoder in the arbitration path, so the arbitration decision can run ahead of grant servicing.

## Interface
- HOLD_MAX, default 15: maximum GRANT cycles before a forced release (timeout build only); legal range 1..255.
- clk  input  1  rising-edge clock.
- rstN  input  1  asynchronous active-low reset.
- idx_valid  input  1  index offered.
- idx  input  3  encoded priority: 0..3 = requester number, 7 = none, 4..6 illegal.
- idx_ready  output  1  buffer can accept; equals (count < 2).
- grant  output  4  one-hot grant, registered.
- grant_done  input  1  requester has finished with its grant.
- busy  output  1  high in GRANT state.
- none_seen  output  1  one-cycle pulse when code 7 is consumed.
- idx_err  output  1  one-cycle pulse when a code 4..6 is consumed.
- timeout  output  1  one-cycle pulse on forced release; present only with PRIORITY_GRANT_TIMEOUT_EN.

## Operation
- Reset (rstN low, asynchronous): FIFO empty (count=0), state IDLE, grant=4'b0000, busy=0, none_seen=0, idx_err=0, timeout=0, counter=0. idx_ready is 1 after reset.
- Input FIFO: 2 entries × 3 bits, with wrapping read/write pointers and a 2-bit count.
  - Push when idx_valid && idx_ready.
  - No bypass: an index must be written before it can be popped.
  - A push and a pop in the same cycle leave count unchanged.
- FSM states: IDLE, GRANT.
  - IDLE with count>0: pop the head entry.
    - Code 0..3: grant <= 1<<code; go to GRANT.
    - Code 7: pulse none_seen; stay in IDLE.
    - Code 4..6: pulse idx_err; discard; stay in IDLE.
  - IDLE with count==0: hold.
  - GRANT: grant is held stable and no pop occurs.
    - grant_done==1 at an edge: grant <= 0, go to IDLE.
  - grant_done is ignored in IDLE.
- Pulse outputs are registered and high for exactly one cycle per event.

## Timing
- Acceptance at edge k, FIFO empty, IDLE: grant or pulse is visible after edge k+1.
- Done sampled at edge m: grant falls after edge m. The next pop happens at edge m+1 at the earliest, so there is at least one all-zero grant cycle between consecutive grants.
- Back-to-back none/illegal codes are consumed one per cycle.
- idx_ready deasserts in the cycle after count reaches 2. It reasserts in the cycle after a pop brings count to 1.
- Reset mid-GRANT: grant drops immediately (asynchronous) and the FIFO contents are lost.

## Configuration
- PRIORITY_GRANT_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter reaches HOLD_MAX without grant_done: grant <= 0, timeout pulses, go to IDLE.
  - If grant_done and the limit occur on the same edge, grant_done wins and timeout stays low.
- PRIORITY_GRANT_TIMEOUT_EN not defined: no counter and no timeout port. GRANT waits indefinitely for grant_done.

## Structure
- Shared package priority_pkg holds:
  - the state enum (IDLE, GRANT);
  - NONE_CODE = 3'd7;
  - the requester count constant 4;
  - an index-to-one-hot function also reused by the decoder testbench.
- One sub-module, priority_idx_fifo: 2-entry FIFO with push, pop, full, empty and count.
- The FSM, pulse logic and timeout counter live in the top module.

## Test plan
- Push idx=2 into an empty FIFO: grant=4'b0100 one edge after acceptance. Assert grant_done 3 cycles later: grant=0 after that edge.
- Push 1, 3, 0 back-to-back while the first grant is held: idx_ready=0 after two entries are buffered. The grants then follow 4'b0010, 4'b1000, 4'b0001, each separated by at least one zero cycle.
- Push 7 then 5: none_seen pulses once, idx_err pulses on the next cycle, and grant stays 0.
- Timeout build, HOLD_MAX=4, push 0, never assert done: timeout pulses, grant releases after 4 GRANT cycles, and the next entry is served. Repeat with grant_done on the 4th cycle: no timeout pulse.
- Assert rstN low mid-GRANT with a full FIFO: grant=0 immediately, and idx_ready=1 and all pulses 0 after release. A push after reset is served normally.
- Push and pop on the same cycle with count=1: count stays 1, and entry order is preserved.
